// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: unit-select encoding, FSM states and requester IDs.
package alu_arbiter_pkg;

  localparam logic [2:0] UNIT_ADD  = 3'b000;
  localparam logic [2:0] UNIT_MUL  = 3'b001;
  localparam logic [2:0] UNIT_SHF  = 3'b010;
  localparam logic [2:0] UNIT_MOV  = 3'b011;
  localparam logic [2:0] UNIT_OR   = 3'b100;
  localparam logic [2:0] UNIT_XOR  = 3'b101;
  localparam logic [2:0] UNIT_AND  = 3'b110;
  localparam logic [2:0] UNIT_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_ADDR = 1'b1;

  function automatic logic [1:0] oneHot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU shared by both requesters; fed only from registered operands.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        unit_sel_i,
  input  logic              op_sel_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] src_i,
  output logic [DATA_W-1:0] res_o
);

  // Signedness of the multiply cannot change the low half of the product, so both
  // flavours share one unsigned multiplier.
  always_comb begin
    res_o = '0;
    case (unit_sel_i)
      UNIT_ADD:  res_o = op_sel_i ? (acc_i + ~src_i + DATA_W'(1)) : (acc_i + src_i);
      UNIT_MUL:  res_o = acc_i * src_i;
      UNIT_SHF:  res_o = op_sel_i ? (acc_i >> src_i[2:0]) : (acc_i << src_i[2:0]);
      UNIT_MOV:  res_o = src_i;
      UNIT_OR:   res_o = acc_i | src_i;
      UNIT_XOR:  res_o = acc_i ^ src_i;
      UNIT_AND:  res_o = acc_i & src_i;
      UNIT_PASS: res_o = acc_i;
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around a single ALU: grant in IDLE, evaluate in EXEC,
// pulse done in DONE. Round-robin or fixed priority on ties.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        req_in,
  input  logic [2:0]        r0_unit_sel_in,
  input  logic              r0_op_sel_in,
  input  logic [DATA_W-1:0] r0_acc_in,
  input  logic [DATA_W-1:0] r0_src_in,
  input  logic [2:0]        r1_unit_sel_in,
  input  logic              r1_op_sel_in,
  input  logic [DATA_W-1:0] r1_acc_in,
  input  logic [DATA_W-1:0] r1_src_in,
  output logic [1:0]        gnt_out,
  output logic [1:0]        done_out,
  output logic [DATA_W-1:0] res_out,
  output logic              zero_out,
  output logic              busy_out
);

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic [2:0]        unit_q;
  logic              opsel_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] src_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              busy_q;
  logic              winner_d;
  logic [DATA_W-1:0] aluRes;

  // On a tie, round-robin picks whoever was not served last; fixed priority picks r0.
  always_comb begin
    winner_d = REQ_EXEC;
    if (req_in == 2'b10) begin
      winner_d = REQ_ADDR;
    end else if (req_in == 2'b11) begin
      winner_d = RR_EN ? ~last_q : REQ_EXEC;
    end
  end

  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .unit_sel_i (unit_q),
    .op_sel_i   (opsel_q),
    .acc_i      (acc_q),
    .src_i      (src_q),
    .res_o      (aluRes)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_EXEC;
      last_q  <= REQ_ADDR;
      unit_q  <= UNIT_ADD;
      opsel_q <= 1'b0;
      acc_q   <= '0;
      src_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      res_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_in != 2'b00) begin
            unit_q  <= winner_d ? r1_unit_sel_in : r0_unit_sel_in;
            opsel_q <= winner_d ? r1_op_sel_in   : r0_op_sel_in;
            acc_q   <= winner_d ? r1_acc_in      : r0_acc_in;
            src_q   <= winner_d ? r1_src_in      : r0_src_in;
            owner_q <= winner_d;
            gnt_q   <= oneHot(winner_d);
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= aluRes;
          zero_q  <= (aluRes == '0);
          last_q  <= owner_q;
          done_q  <= oneHot(owner_q);
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_out  = gnt_q;
  assign done_out = done_q;
  assign res_out  = res_q;
  assign zero_out = zero_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus;
// results are checked against constant tables and an arithmetic reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [2:0] u0, u1;
  logic       o0, o1;
  logic [7:0] a0, s0, a1, s1;

  logic [1:0] gntR, doneR, gntF, doneF;
  logic [7:0] resR, resF;
  logic       zeroR, busyR, zeroF, busyF;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic       id;
    logic [2:0] unit;
    logic       op;
    logic [7:0] acc;
    logic [7:0] src;
    logic [7:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1), .DATA_W(8)) dutRr (
    .clk_in(clk), .rst_in(rst), .req_in(req),
    .r0_unit_sel_in(u0), .r0_op_sel_in(o0), .r0_acc_in(a0), .r0_src_in(s0),
    .r1_unit_sel_in(u1), .r1_op_sel_in(o1), .r1_acc_in(a1), .r1_src_in(s1),
    .gnt_out(gntR), .done_out(doneR), .res_out(resR), .zero_out(zeroR), .busy_out(busyR)
  );

  alu_arbiter #(.RR_EN(1'b0), .DATA_W(8)) dutFixed (
    .clk_in(clk), .rst_in(rst), .req_in(req),
    .r0_unit_sel_in(u0), .r0_op_sel_in(o0), .r0_acc_in(a0), .r0_src_in(s0),
    .r1_unit_sel_in(u1), .r1_op_sel_in(o1), .r1_acc_in(a1), .r1_src_in(s1),
    .gnt_out(gntF), .done_out(doneF), .res_out(resF), .zero_out(zeroF), .busy_out(busyF)
  );

  // Reference ALU written from the arithmetic rules, independent of bit tricks.
  function automatic logic [7:0] aluModel(input logic [2:0] u, input logic o,
                                          input logic [7:0] a, input logic [7:0] s);
    int ai, si, sa, ss, sh, r;
    ai = int'(a);
    si = int'(s);
    sa = a[7] ? ai - 256 : ai;
    ss = s[7] ? si - 256 : si;
    sh = si % 8;
    r = 0;
    case (u)
      3'd0: r = o ? ai - si : ai + si;
      3'd1: r = o ? sa * ss : ai * si;
      3'd2: r = o ? ai / (2 ** sh) : ai * (2 ** sh);
      3'd3: r = si;
      3'd4: r = int'(a | s);
      3'd5: r = int'(a ^ s);
      3'd6: r = int'(a & s);
      default: r = ai;
    endcase
    return 8'(r);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r,
                               input logic [2:0] iu0, input logic io0, input logic [7:0] ia0, input logic [7:0] is0,
                               input logic [2:0] iu1, input logic io1, input logic [7:0] ia1, input logic [7:0] is1);
    req = r;
    u0 = iu0; o0 = io0; a0 = ia0; s0 = is0;
    u1 = iu1; o1 = io1; a1 = ia1; s1 = is1;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (doneR != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, 8'(seen), 8'd1);
  endtask

  task automatic goIdle(input string name);
    req = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (!busyR && !busyF) break;
      step();
    end
    checkOutput({name, "_idle"}, 8'(busyR | busyF), 8'd0);
  endtask

  task automatic doReset();
    req = 2'b00;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lastSrv;
    logic [1:0] rm;
    logic winR, winF;
    logic [7:0] expR, expF;

    vecs[0]  = '{1'b0, UNIT_ADD,  1'b0, 8'h05, 8'h03, 8'h08, 1'b0};
    vecs[1]  = '{1'b1, UNIT_ADD,  1'b1, 8'h05, 8'h05, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, UNIT_MUL,  1'b0, 8'h10, 8'h11, 8'h10, 1'b0};
    vecs[3]  = '{1'b1, UNIT_MUL,  1'b1, 8'hFF, 8'h02, 8'hFE, 1'b0};
    vecs[4]  = '{1'b0, UNIT_SHF,  1'b0, 8'h81, 8'h09, 8'h02, 1'b0};
    vecs[5]  = '{1'b1, UNIT_SHF,  1'b1, 8'h80, 8'h03, 8'h10, 1'b0};
    vecs[6]  = '{1'b0, UNIT_MOV,  1'b0, 8'h00, 8'h5A, 8'h5A, 1'b0};
    vecs[7]  = '{1'b1, UNIT_OR,   1'b0, 8'h0F, 8'hF0, 8'hFF, 1'b0};
    vecs[8]  = '{1'b0, UNIT_XOR,  1'b0, 8'hAA, 8'hAA, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, UNIT_AND,  1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[10] = '{1'b0, UNIT_PASS, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1};
    vecs[11] = '{1'b1, UNIT_PASS, 1'b1, 8'h42, 8'h00, 8'h42, 1'b0};
    vecs[12] = '{1'b0, UNIT_ADD,  1'b1, 8'h03, 8'h05, 8'hFE, 1'b0};

    applyStimulus(2'b00, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    step();
    checkOutput("rst_gnt",  8'(gntR),  8'h00);
    checkOutput("rst_done", 8'(doneR), 8'h00);
    checkOutput("rst_res",  resR,      8'h00);
    checkOutput("rst_zero", 8'(zeroR), 8'h00);
    checkOutput("rst_busy", 8'(busyR), 8'h00);
    checkOutput("rst_busyF", 8'(busyF), 8'h00);
    rst = 1'b0;
    step();

    // Exact latency of one r0 add.
    applyStimulus(2'b01, UNIT_ADD, 1'b0, 8'h05, 8'h03, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    checkOutput("lat_gnt_t1",  8'(gntR),  8'h01);
    checkOutput("lat_done_t1", 8'(doneR), 8'h00);
    checkOutput("lat_busy_t1", 8'(busyR), 8'h01);
    step();
    checkOutput("lat_gnt_t2",  8'(gntR),  8'h01);
    checkOutput("lat_done_t2", 8'(doneR), 8'h01);
    checkOutput("lat_res_t2",  resR,      8'h08);
    checkOutput("lat_zero_t2", 8'(zeroR), 8'h00);
    req = 2'b00;
    step();
    checkOutput("lat_done_t3", 8'(doneR), 8'h00);
    checkOutput("lat_gnt_t3",  8'(gntR),  8'h00);
    checkOutput("lat_res_hold", resR,     8'h08);
    checkOutput("lat_busy_t3", 8'(busyR), 8'h00);

    // Table of single-requester ops, with junk in the idle requester's slot.
    for (int k = 0; k < 13; k++) begin
      if (vecs[k].id == REQ_EXEC)
        applyStimulus(2'b01, vecs[k].unit, vecs[k].op, vecs[k].acc, vecs[k].src,
                      3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      else
        applyStimulus(2'b10, 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                      vecs[k].unit, vecs[k].op, vecs[k].acc, vecs[k].src);
      waitDone($sformatf("vec%0d", k));
      checkOutput($sformatf("vec%0d_done", k),  8'(doneR), 8'(oneHot(vecs[k].id)));
      checkOutput($sformatf("vec%0d_doneF", k), 8'(doneF), 8'(oneHot(vecs[k].id)));
      checkOutput($sformatf("vec%0d_res", k),   resR,      vecs[k].res);
      checkOutput($sformatf("vec%0d_resF", k),  resF,      vecs[k].res);
      checkOutput($sformatf("vec%0d_zero", k),  8'(zeroR), 8'(vecs[k].zero));
      goIdle($sformatf("vec%0d", k));
    end

    // Ties from reset: round-robin alternates, fixed priority always picks r0.
    doReset();
    applyStimulus(2'b11, UNIT_SHF, 1'b1, 8'h80, 8'h03, UNIT_OR, 1'b0, 8'h0F, 8'hF0);
    for (int k = 0; k < 4; k++) begin
      waitDone($sformatf("tie%0d", k));
      checkOutput($sformatf("tie%0d_doneR", k), 8'(doneR), (k % 2 == 0) ? 8'h01 : 8'h02);
      checkOutput($sformatf("tie%0d_resR", k),  resR,      (k % 2 == 0) ? 8'h10 : 8'hFF);
      checkOutput($sformatf("tie%0d_doneF", k), 8'(doneF), 8'h01);
      checkOutput($sformatf("tie%0d_resF", k),  resF,      8'h10);
    end
    req = 2'b10;
    waitDone("tie_r1only");
    checkOutput("tie_r1only_doneF", 8'(doneF), 8'h02);
    checkOutput("tie_r1only_resF",  resF,      8'hFF);
    checkOutput("tie_r1only_doneR", 8'(doneR), 8'h02);
    goIdle("tie");

    // Operands are latched at grant time.
    applyStimulus(2'b01, UNIT_ADD, 1'b0, 8'h05, 8'h03, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    checkOutput("latch_busy", 8'(busyR), 8'h01);
    a0 = 8'h7F;
    waitDone("latch");
    checkOutput("latch_res", resR, 8'h08);
    goIdle("latch");

    // Dropping req during EXEC still completes the op.
    applyStimulus(2'b01, UNIT_MOV, 1'b0, 8'h00, 8'h3C, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    req = 2'b00;
    waitDone("drop");
    checkOutput("drop_done", 8'(doneR), 8'h01);
    checkOutput("drop_res",  resR,      8'h3C);
    goIdle("drop");

    // Reset in EXEC discards the op; held request is regranted afterwards.
    applyStimulus(2'b01, UNIT_ADD, 1'b0, 8'h05, 8'h03, 3'd0, 1'b0, 8'h00, 8'h00);
    step();
    #2 rst = 1'b1;
    #1;
    checkOutput("rstx_res",  resR,      8'h00);
    checkOutput("rstx_busy", 8'(busyR), 8'h00);
    checkOutput("rstx_gnt",  8'(gntR),  8'h00);
    step();
    checkOutput("rstx_done", 8'(doneR), 8'h00);
    rst = 1'b0;
    step();
    checkOutput("rstx_regnt", 8'(gntR), 8'h01);
    waitDone("rstx");
    checkOutput("rstx_res2", resR, 8'h08);
    goIdle("rstx");

    // Random ops against the reference model.
    doReset();
    lastSrv = 1;
    for (int k = 0; k < 40; k++) begin
      rm = 2'($urandom_range(1, 3));
      applyStimulus(rm, 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      if (rm == 2'b11) winR = (lastSrv == 0);
      else             winR = (rm == 2'b10);
      winF = (rm == 2'b10);
      expR = winR ? aluModel(u1, o1, a1, s1) : aluModel(u0, o0, a0, s0);
      expF = winF ? aluModel(u1, o1, a1, s1) : aluModel(u0, o0, a0, s0);
      waitDone($sformatf("rnd%0d", k));
      checkOutput($sformatf("rnd%0d_doneR", k), 8'(doneR), winR ? 8'h02 : 8'h01);
      checkOutput($sformatf("rnd%0d_resR", k),  resR,      expR);
      checkOutput($sformatf("rnd%0d_zeroR", k), 8'(zeroR), 8'(expR == 8'h00));
      checkOutput($sformatf("rnd%0d_doneF", k), 8'(doneF), winF ? 8'h02 : 8'h01);
      checkOutput($sformatf("rnd%0d_resF", k),  resF,      expF);
      lastSrv = winR ? 1 : 0;
      goIdle($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
